// File: rtl/alu_control_seq.sv
// ALU control decoder with registered output and valid/ready handshake; ALUCTL_PERF_CNT_EN adds perf counters.
// Latency: single-cycle ops valid on the accept edge; mul/div valid MUL_CYCLES/DIV_CYCLES edges after accept.
// Backpressure: result held while ctrl_ready=0; in_ready low during multi-cycle ops (busy stalls upstream).
module alu_control_seq #(
   parameter int OP_W       = 4,
   parameter int FUNCT_W    = 6,
   parameter int CTRL_W     = 4,
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [OP_W-1:0]    alu_op,
   input  logic [FUNCT_W-1:0] funct,
   output logic [CTRL_W-1:0]  ctrl_out,
   output logic               ctrl_valid,
   input  logic               ctrl_ready,
   output logic               busy,
   output logic               illegal
`ifdef ALUCTL_PERF_CNT_EN
   ,
   output logic [31:0]        perf_ops,
   output logic [31:0]        perf_stall
`endif
);

   localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [CTRL_W-1:0] dec_ctrl;
   logic              dec_ill;
   logic              dec_mul;
   logic              dec_div;
   logic              accept;

   assign in_ready = rst_n && ((state == IDLE) || ((state == HOLD) && ctrl_ready));
   assign accept   = in_valid && in_ready;

   always_comb begin
      dec_ctrl = '0;
      dec_ill  = 1'b0;
      case (alu_op)
         OP_W'(0), OP_W'(3): dec_ctrl = CTRL_W'(4'b0010);
         OP_W'(1):           dec_ctrl = CTRL_W'(4'b1000);
         OP_W'(4):           dec_ctrl = CTRL_W'(4'b0000);
         OP_W'(5):           dec_ctrl = CTRL_W'(4'b0001);
         OP_W'(6):           dec_ctrl = CTRL_W'(4'b0111);
         OP_W'(7):           dec_ctrl = CTRL_W'(4'b1001);
         OP_W'(8):           dec_ctrl = CTRL_W'(4'b0011);
         OP_W'(9):           dec_ctrl = CTRL_W'(4'b0110);
         OP_W'(2): begin
            case (funct)
               FUNCT_W'(6'b100000): dec_ctrl = CTRL_W'(4'b0010);
               FUNCT_W'(6'b100010): dec_ctrl = CTRL_W'(4'b0110);
               FUNCT_W'(6'b000010): dec_ctrl = CTRL_W'(4'b0011);
               FUNCT_W'(6'b011010): dec_ctrl = CTRL_W'(4'b0100);
               FUNCT_W'(6'b100100): dec_ctrl = CTRL_W'(4'b0000);
               FUNCT_W'(6'b100101): dec_ctrl = CTRL_W'(4'b0001);
               FUNCT_W'(6'b101010): dec_ctrl = CTRL_W'(4'b0111);
               FUNCT_W'(6'b000000): dec_ctrl = CTRL_W'(4'b0101);
               FUNCT_W'(6'b100111): dec_ctrl = CTRL_W'(4'b0101);
               FUNCT_W'(6'b100110): dec_ctrl = CTRL_W'(4'b1001);
               FUNCT_W'(6'b101100): dec_ctrl = CTRL_W'(4'b1010);
               default:             dec_ill  = 1'b1;
            endcase
         end
         default: dec_ill = 1'b1;
      endcase
      if (dec_ill) dec_ctrl = CTRL_W'(4'b0101);
   end

   // Multi-cycle class follows the decoded code, so alu_op=8 is a multiply too.
   assign dec_mul = !dec_ill && (dec_ctrl == CTRL_W'(4'b0011));
   assign dec_div = !dec_ill && (dec_ctrl == CTRL_W'(4'b0100));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         ctrl_out   <= '0;
         ctrl_valid <= 1'b0;
         busy       <= 1'b0;
         illegal    <= 1'b0;
      end else begin
         case (state)
            IDLE, HOLD: begin
               if (accept) begin
                  ctrl_out <= dec_ctrl;
                  illegal  <= dec_ill;
                  if (dec_mul || dec_div) begin
                     state      <= EXEC;
                     cnt        <= dec_mul ? CNT_W'(MUL_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
                     busy       <= 1'b1;
                     ctrl_valid <= 1'b0;
                  end else begin
                     state      <= HOLD;
                     ctrl_valid <= 1'b1;
                  end
               end else if ((state == HOLD) && ctrl_ready) begin
                  state      <= IDLE;
                  ctrl_valid <= 1'b0;
               end
            end
            EXEC: begin
               // busy drops after N-1 cycles; the result is published one edge later (N edges total).
               if (cnt == CNT_W'(1)) begin
                  busy <= 1'b0;
                  cnt  <= '0;
               end else if (cnt == '0) begin
                  state      <= HOLD;
                  ctrl_valid <= 1'b1;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ALUCTL_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_ops   <= '0;
         perf_stall <= '0;
      end else begin
         if (accept) perf_ops <= perf_ops + 32'd1;
         if (busy)   perf_stall <= perf_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_control_seq.sv
// Randomized bench for alu_control_seq against a table-driven transaction model.
module tb_alu_control_seq;
   localparam int MULC = 4;
   localparam int DIVC = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] alu_op = '0;
   logic [5:0] funct = '0;
   logic [3:0] ctrl_out;
   logic       ctrl_valid;
   logic       ctrl_ready = 1'b0;
   logic       busy;
   logic       illegal;
`ifdef ALUCTL_PERF_CNT_EN
   logic [31:0] perf_ops;
   logic [31:0] perf_stall;
`endif

   alu_control_seq #(.OP_W(4), .FUNCT_W(6), .CTRL_W(4), .MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .alu_op(alu_op), .funct(funct), .ctrl_out(ctrl_out), .ctrl_valid(ctrl_valid),
      .ctrl_ready(ctrl_ready), .busy(busy), .illegal(illegal)
`ifdef ALUCTL_PERF_CNT_EN
      , .perf_ops(perf_ops), .perf_stall(perf_stall)
`endif
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   int op_tab[16];
   int fn_tab[int];
   int fl[11] = '{32, 34, 2, 26, 36, 37, 42, 0, 39, 38, 44};
   int exp_ops = 0;
   int exp_stall = 0;
   int last_ctrl = 0;
   int last_ill = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Reference: table lookup, illegal -> 0101, latency 0 (same edge) or N edges for mul/div codes.
   task automatic ref_op(input int op, input int f, output int c, output int il, output int lat);
      int v;
      v = op_tab[op];
      if (op == 2) v = fn_tab.exists(f) ? fn_tab[f] : -1;
      if (v < 0) begin
         c = 5; il = 1; lat = 0;
      end else begin
         c = v; il = 0;
         lat = (v == 3) ? MULC : (v == 4) ? DIVC : 0;
      end
   endtask

   // Called just after a negedge; leaves the bench at the negedge where ctrl_valid is seen.
   task automatic issue(input int op, input int f, input logic b2b);
      int c, il, elat, lat, nb;
      ref_op(op, f, c, il, elat);
      in_valid = 1'b1; alu_op = 4'(op); funct = 6'(f); ctrl_ready = b2b;
      #1 chk("in_ready_at_issue", {31'b0, in_ready}, 1);
      @(negedge clk);
      in_valid = 1'b0; ctrl_ready = 1'b0;
      exp_ops++;
      if (elat > 0) exp_stall += elat - 1;
      lat = 0; nb = 0;
      while (ctrl_valid !== 1'b1 && lat < 40) begin
         if (busy === 1'b1) nb++;
         chk("in_ready_exec", {31'b0, in_ready}, 0);
         @(negedge clk);
         lat++;
      end
      chk("latency", lat, elat);
      chk("busy_cycles", nb, (elat > 0) ? elat - 1 : 0);
      chk("ctrl_out", {28'b0, ctrl_out}, c);
      chk("illegal", {31'b0, illegal}, il);
      last_ctrl = c; last_ill = il;
   endtask

   task automatic hold(input int k);
      for (int i = 0; i < k; i++) begin
         ctrl_ready = 1'b0;
         @(negedge clk);
         chk("hold_ctrl_out", {28'b0, ctrl_out}, last_ctrl);
         chk("hold_valid", {31'b0, ctrl_valid}, 1);
         chk("hold_illegal", {31'b0, illegal}, last_ill);
      end
   endtask

   task automatic release_op();
      ctrl_ready = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      ctrl_ready = 1'b0;
      chk("release_valid", {31'b0, ctrl_valid}, 0);
      chk("release_ctrl_out", {28'b0, ctrl_out}, last_ctrl);
      #1 chk("idle_in_ready", {31'b0, in_ready}, 1);
   endtask

   task automatic check_perf();
`ifdef ALUCTL_PERF_CNT_EN
      chk("perf_ops", perf_ops, exp_ops);
      chk("perf_stall", perf_stall, exp_stall);
`endif
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ctrl_out"}, {28'b0, ctrl_out}, 0);
      chk({tag, "_valid"}, {31'b0, ctrl_valid}, 0);
      chk({tag, "_busy"}, {31'b0, busy}, 0);
      chk({tag, "_illegal"}, {31'b0, illegal}, 0);
   endtask

   initial begin
      int vcnt;
      op_tab = '{2, 8, -1, 2, 0, 1, 7, 9, 3, 6, -1, -1, -1, -1, -1, -1};
      fn_tab[32] = 2; fn_tab[34] = 6; fn_tab[2] = 3; fn_tab[26] = 4;
      fn_tab[36] = 0; fn_tab[37] = 1; fn_tab[42] = 7; fn_tab[0] = 5;
      fn_tab[39] = 5; fn_tab[38] = 9; fn_tab[44] = 10;

      #2 rst_n = 1'b0;
      #1 chk("rst_in_ready", {31'b0, in_ready}, 0);
      check_reset_outputs("rst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1 chk("post_rst_in_ready", {31'b0, in_ready}, 1);
      check_reset_outputs("post_rst");
      check_perf();

      // Plain add, then multiply with stalls, then back-to-back beq, then illegal ops.
      issue(2, 32, 1'b0);
      release_op();
      issue(2, 2, 1'b0);
      hold(3);
      issue(1, 0, 1'b1);
      release_op();
      issue(2, 63, 1'b0);
      hold(1);
      issue(12, 0, 1'b1);
      release_op();
      check_perf();

      for (int n = 0; n < 60; n++) begin
         int op, f;
         op = int'($urandom_range(0, 15));
         if (($urandom & 1) != 0) begin
            op = 2;
            f = fl[$urandom_range(0, 10)];
         end else begin
            f = int'($urandom_range(0, 63));
         end
         issue(op, f, 1'b0);
         hold(int'($urandom_range(0, 2)));
         if (($urandom & 1) != 0) begin
            issue(int'($urandom_range(0, 9)), fl[$urandom_range(0, 10)], 1'b1);
         end
         release_op();
      end
      check_perf();

      // Mid-HOLD reset drops everything asynchronously.
      issue(5, 0, 1'b0);
      #2 rst_n = 1'b0;
      #1 chk("mid_rst_in_ready", {31'b0, in_ready}, 0);
      check_reset_outputs("mid_rst");
      @(negedge clk);
      rst_n = 1'b1;
      exp_ops = 0; exp_stall = 0;
      #1 chk("mid_post_in_ready", {31'b0, in_ready}, 1);
      check_reset_outputs("mid_post");

      // Divide aborted by reset at cycle 5: no result ever appears.
      @(negedge clk);
      in_valid = 1'b1; alu_op = 4'd2; funct = 6'b011010;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("div_busy_before_abort", {31'b0, busy}, 1);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("abort");
      @(negedge clk);
      rst_n = 1'b1;
      vcnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ctrl_valid !== 1'b0) vcnt++;
      end
      chk("abort_valid_cycles", vcnt, 0);
      chk("abort_in_ready", {31'b0, in_ready}, 1);
      chk("abort_busy", {31'b0, busy}, 0);
      check_perf();

      issue(2, 26, 1'b0);
      release_op();
      check_perf();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule
